// File: rtl/pic8259_pkg.sv
// Shared constants, acknowledge-FSM state type and priority-rank helper for the 8259-style resolver.
package pic8259_pkg;

    localparam int unsigned NUM_IR  = 8;
    localparam int unsigned LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] RESET_LP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK1,
        ST_ACK2
    } ack_state_t;

    // Distance from the highest-priority level (LP+1); 0 is most urgent.
    function automatic logic [LEVEL_W-1:0] prio_rank(input logic [LEVEL_W-1:0] level,
                                                     input logic [LEVEL_W-1:0] lp);
        return level - lp - LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/rot_priority_enc.sv
// Rotating priority encoder: picks the set bit closest after lp, wrapping cyclically.
module rot_priority_enc
    import pic8259_pkg::*;
(
    input  logic [NUM_IR-1:0]  vec,
    input  logic [LEVEL_W-1:0] lp,
    output logic               valid,
    output logic [LEVEL_W-1:0] level
);

    // Scan from lowest to highest priority so the most urgent hit is written last.
    always_comb begin
        valid = 1'b0;
        level = '0;
        for (int i = NUM_IR; i >= 1; i--) begin
            if (vec[LEVEL_W'(int'(lp) + i)]) begin
                valid = 1'b1;
                level = LEVEL_W'(int'(lp) + i);
            end
        end
    end

endmodule

// File: rtl/isr_priority_resolver.sv
// 8259-style in-service register, rotating priority resolver and INTA acknowledge sequencer.
// Optional build macro SPECIAL_MASK_MODE_EN adds the SMM input (masked ISR bits ignored).
module isr_priority_resolver
    import pic8259_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IR-1:0]   IRR,
    input  logic [NUM_IR-1:0]   Mask,
    input  logic                INTA_n,
    input  logic [4:0]          ICW2_base,
    input  logic                AEOI,
    input  logic                Rotate_AEOI,
    input  logic                EOI_cmd,
    input  logic                SEOI_cmd,
    input  logic                Set_pri_cmd,
    input  logic                Cmd_rotate,
    input  logic [LEVEL_W-1:0]  Cmd_level,
`ifdef SPECIAL_MASK_MODE_EN
    input  logic                SMM,
`endif
    output logic                INT,
    output logic [NUM_IR-1:0]   ISR,
    output logic [7:0]          Vector,
    output logic                Vector_oe,
    output logic [LEVEL_W-1:0]  Int_level,
    output logic [NUM_IR-1:0]   Clear_IRR
);

    ack_state_t          state;
    logic [LEVEL_W-1:0]  lp;
    logic [LEVEL_W-1:0]  lp_next;
    logic                inta_prev;
    logic                spurious;
    logic                smm;
    logic [NUM_IR-1:0]   cand;
    logic [NUM_IR-1:0]   isr_eff;
    logic                cand_valid;
    logic [LEVEL_W-1:0]  cand_level;
    logic                isr_valid;
    logic [LEVEL_W-1:0]  isr_level;
    logic                int_req;
    logic                inta_edge;
    logic [NUM_IR-1:0]   isr_set;
    logic [NUM_IR-1:0]   isr_clr;

`ifdef SPECIAL_MASK_MODE_EN
    assign smm = SMM;
`else
    assign smm = 1'b0;
`endif

    assign cand      = IRR & ~Mask;
    assign isr_eff   = ISR & ~(Mask & {NUM_IR{smm}});
    assign inta_edge = inta_prev & ~INTA_n;

    rot_priority_enc u_cand_enc (
        .vec   (cand),
        .lp    (lp),
        .valid (cand_valid),
        .level (cand_level)
    );

    rot_priority_enc u_isr_enc (
        .vec   (isr_eff),
        .lp    (lp),
        .valid (isr_valid),
        .level (isr_level)
    );

    assign int_req = cand_valid &&
                     (!isr_valid || (prio_rank(cand_level, lp) < prio_rank(isr_level, lp)));

    // ISR clear/set masks and LP update; clears apply before the acknowledge set.
    always_comb begin
        isr_set = '0;
        isr_clr = '0;
        lp_next = lp;
        if (state == ST_IDLE && inta_edge && cand_valid) begin
            isr_set[cand_level] = 1'b1;
        end
        if (state == ST_ACK2 && INTA_n && AEOI && !spurious) begin
            isr_clr[Int_level] = 1'b1;
            if (Rotate_AEOI) begin
                lp_next = Int_level;
            end
        end
        if (EOI_cmd && isr_valid) begin
            isr_clr[isr_level] = 1'b1;
            if (Cmd_rotate) begin
                lp_next = isr_level;
            end
        end
        if (SEOI_cmd) begin
            isr_clr[Cmd_level] = 1'b1;
            if (Cmd_rotate) begin
                lp_next = Cmd_level;
            end
        end
        if (Set_pri_cmd) begin
            lp_next = Cmd_level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ISR       <= '0;
            lp        <= RESET_LP;
            INT       <= 1'b0;
            Vector_oe <= 1'b0;
            Vector    <= '0;
            Int_level <= '0;
            Clear_IRR <= '0;
            inta_prev <= 1'b1;
            spurious  <= 1'b0;
        end else begin
            Clear_IRR <= '0;
            INT       <= 1'b0;
            inta_prev <= INTA_n;
            ISR       <= (ISR & ~isr_clr) | isr_set;
            lp        <= lp_next;
            case (state)
                ST_IDLE: begin
                    if (inta_edge) begin
                        state <= ST_ACK1;
                        if (cand_valid) begin
                            Int_level <= cand_level;
                            Clear_IRR <= NUM_IR'(1) << cand_level;
                            spurious  <= 1'b0;
                        end else begin
                            Int_level <= LEVEL_W'(7);
                            spurious  <= 1'b1;
                        end
                    end else begin
                        INT <= int_req;
                    end
                end
                ST_ACK1: begin
                    if (inta_edge) begin
                        state     <= ST_ACK2;
                        Vector_oe <= 1'b1;
                        Vector    <= {ICW2_base, Int_level};
                    end
                end
                ST_ACK2: begin
                    if (INTA_n) begin
                        Vector_oe <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
